if_fetch_stage: RTL
===================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register in the 5-stage MIPS-style core.
- Owns the PC and issues requests on a req/ready instruction-memory interface, holding the address stable until the memory accepts it.
- Buffers one returned instruction while the pipeline is stalled.
- Drives pc/inst plus hold and flush controls into IF/ID; applies branch and jump redirects resolved in ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, byte increment between sequential instructions.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
stall_i  in  1  hazard-unit stall; freeze PC and the IF/ID contents
branch_i  in  1  taken branch resolved in ID
branch_target_i  in  32  branch target address
jump_i  in  1  jump resolved in ID
jump_target_i  in  32  jump target address
imem_req_o  out  1  instruction-memory request valid
imem_addr_o  out  32  request address, word aligned
imem_ready_i  in  1  memory accepts the request; imem_rdata_i valid in the same cycle
imem_rdata_i  in  32  instruction word
pc_o  out  32  to IF/ID pc_i: fetched PC + PC_STEP
inst_o  out  32  to IF/ID inst_i
ifid_hold_o  out  1  to IF/ID IFIDwrite_i; 1 = hold contents
ifid_flush_o  out  1  to IF/ID flush_i; 1 = load zero (nop bubble)

Behaviour:
- Registers:
  - pc_q: next fetch address.
  - oaddr_q: address of the outstanding discarded request.
  - buf_q: buffered instruction (32 bits).
  - bufpc_q: PC of the buffered instruction.
  - state: FETCH, HOLD or DISCARD.
- Reset (rst_i low, asynchronous): pc_q = RESET_PC; oaddr_q, buf_q and bufpc_q = 0; state = FETCH.
  - While reset is asserted, combinational outputs are forced: imem_req_o = 0, ifid_flush_o = 1, ifid_hold_o = 0, pc_o = 0, inst_o = 0.
- Redirect: redirect = (branch_i | jump_i) & ~stall_i.
  - target = branch_i ? branch_target_i : jump_target_i (branch wins).
  - Redirects presented while stall_i = 1 are ignored; the hazard unit guarantees they are re-presented.
- FETCH state:
  - imem_req_o = 1, imem_addr_o = pc_q.
  - If redirect and imem_ready_i: data dropped; pc_q <= target; flush = 1; stay in FETCH.
  - If redirect and no ready: oaddr_q <= pc_q; pc_q <= target; flush = 1; go to DISCARD.
  - If imem_ready_i and stall_i: buf_q <= rdata; bufpc_q <= pc_q; pc_q <= pc_q + PC_STEP; hold = 1; go to HOLD.
  - If imem_ready_i and no stall: pc_o = pc_q + PC_STEP; inst_o = rdata; hold = 0; flush = 0; pc_q <= pc_q + PC_STEP.
  - If no ready and stall_i: hold = 1.
  - If no ready and no stall: flush = 1 (bubble).
- HOLD state:
  - imem_req_o = 0.
  - If redirect: buffer dropped; pc_q <= target; flush = 1; go to FETCH.
  - If stall_i: hold = 1.
  - Otherwise: pc_o = bufpc_q + PC_STEP; inst_o = buf_q; hold = 0; flush = 0; go to FETCH.
- DISCARD state:
  - imem_req_o = 1, imem_addr_o = oaddr_q.
  - Flush = 1, or hold = 1 if stall_i.
  - If redirect: pc_q <= target; stay in DISCARD.
  - If imem_ready_i: data dropped; go to FETCH.
- ifid_hold_o and ifid_flush_o are never both 1. Flush has priority only when stall_i = 0.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.
- Latency:
  - Zero-wait memory gives one instruction per cycle into IF/ID.
  - Each wait cycle inserts one bubble.
  - A redirect costs exactly one squashed slot plus any DISCARD wait.

Decomposition:
- Shared package:
  - Fetch state encoding (FETCH = 2'd0, HOLD = 2'd1, DISCARD = 2'd2).
  - INST_NOP = 32'h0.
  - PC_STEP.
- One sub-module is natural: pc_next_sel, the combinational target/increment mux with branch priority.
- FSM, PC register and buffer stay in the top module.

Test Plan:
- Reset with RESET_PC = 0, ready tied to 1, no stall: IF/ID receives (pc, inst) = (4, mem[0]), (8, mem[1]), (12, mem[2]) on consecutive cycles; hold = flush = 0.
- ready low for 2 cycles on address 8: imem_addr_o stays 8; flush = 1 for 2 cycles; then pc_o = 12 and inst_o = mem[2].
- stall_i for 3 cycles coinciding with ready at address 16: hold = 1 for 3 cycles with req dropped after capture; then pc_o = 20 and inst_o = mem[4], with no re-fetch of 16.
- branch_i with target 0x100 while ready is low on address 24: flush = 1; imem_addr_o stays 24 until ready; next request address is 0x100.
- branch_i and jump_i asserted together (targets 0x40 and 0x80): pc_q = 0x40. Redirect with stall_i = 1: ignored, pc_q unchanged.
- rst_i pulled low while in HOLD: all outputs reach reset values immediately; after release, first request address = RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, the nop
// word and the default sequential PC increment.
package if_fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/if_fetch_stage_pc_next_sel.sv
// Combinational next-PC helper: redirect target (branch beats jump) plus the
// sequential increments of the fetch PC and of the buffered instruction's PC.
module pc_next_sel
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] STEP = if_fetch_stage_pkg::PC_STEP
) (
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] bufpc_i,
  output logic [31:0] target_o,
  output logic [31:0] pc_inc_o,
  output logic [31:0] bufpc_inc_o
);

  // Modulo-2^32 adds: the top word address wraps to zero.
  assign target_o    = branch_i ? branch_target_i : jump_target_i;
  assign pc_inc_o    = pc_i + STEP;
  assign bufpc_inc_o = bufpc_i + STEP;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks req/ready to instruction memory,
// buffers one word across stalls and applies ID-resolved redirects.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = if_fetch_stage_pkg::PC_STEP
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        ifid_hold_o,
  output logic        ifid_flush_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  oaddr_q, oaddr_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  bufpc_q, bufpc_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_inc;
  logic [31:0] bufpc_inc;
  logic        req;
  logic [31:0] addr;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        hold;
  logic        flush;

  pc_next_sel #(
    .STEP(PC_STEP)
  ) u_pc_next_sel (
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .jump_target_i   (jump_target_i),
    .pc_i            (pc_q),
    .bufpc_i         (bufpc_q),
    .target_o        (target),
    .pc_inc_o        (pc_inc),
    .bufpc_inc_o     (bufpc_inc)
  );

  // A redirect seen during a stall is dropped; the hazard unit re-presents it.
  assign redirect = (branch_i | jump_i) & ~stall_i;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    oaddr_d  = oaddr_q;
    buf_d    = buf_q;
    bufpc_d  = bufpc_q;
    req      = 1'b0;
    addr     = pc_q;
    hold     = 1'b0;
    flush    = 1'b0;
    pc_out   = 32'h0;
    inst_out = INST_NOP;

    unique case (state_q)
      FETCH: begin
        req = 1'b1;
        if (redirect) begin
          flush = 1'b1;
          pc_d  = target;
          if (!imem_ready_i) begin
            oaddr_d = pc_q;
            state_d = DISCARD;
          end
        end else if (imem_ready_i && stall_i) begin
          hold    = 1'b1;
          buf_d   = imem_rdata_i;
          bufpc_d = pc_q;
          pc_d    = pc_inc;
          state_d = HOLD;
        end else if (imem_ready_i) begin
          pc_out   = pc_inc;
          inst_out = imem_rdata_i;
          pc_d     = pc_inc;
        end else if (stall_i) begin
          hold = 1'b1;
        end else begin
          flush = 1'b1;
        end
      end

      HOLD: begin
        if (redirect) begin
          flush   = 1'b1;
          pc_d    = target;
          state_d = FETCH;
        end else if (stall_i) begin
          hold = 1'b1;
        end else begin
          pc_out   = bufpc_inc;
          inst_out = buf_q;
          state_d  = FETCH;
        end
      end

      DISCARD: begin
        // Keep the abandoned address on the bus until memory takes it.
        req   = 1'b1;
        addr  = oaddr_q;
        hold  = stall_i;
        flush = ~stall_i;
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ready_i) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign imem_req_o   = rst_i ? req : 1'b0;
  assign imem_addr_o  = {addr[31:2], 2'b00};
  assign ifid_hold_o  = rst_i ? hold : 1'b0;
  assign ifid_flush_o = rst_i ? flush : 1'b1;
  assign pc_o         = rst_i ? pc_out : 32'h0;
  assign inst_o       = rst_i ? inst_out : INST_NOP;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      oaddr_q <= 32'h0;
      buf_q   <= 32'h0;
      bufpc_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      oaddr_q <= oaddr_d;
      buf_q   <= buf_d;
      bufpc_q <= bufpc_d;
    end
  end

endmodule
